// File: rtl/mult_pipe_if.sv
`default_nettype none
// ============================================================================
// mult_pipe_if : operand/result handshake bundle for the pipelined multiplier.
// Revision: 1.0
// ============================================================================
interface mult_pipe_if #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 12
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_mplier;
   logic [WIDTH-1:0] in_mcand;
   logic             in_high;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_product;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   // Issuing side: offers operations and consumes results.
   modport master (
      output in_valid, in_mplier, in_mcand, in_high, in_tag, flush, out_ready,
      input  in_ready, out_valid, out_product, out_tag, busy
   );

   // Multiplier side.
   modport slave (
      input  in_valid, in_mplier, in_mcand, in_high, in_tag, flush, out_ready,
      output in_ready, out_valid, out_product, out_tag, busy
   );
endinterface
`default_nettype wire

// File: rtl/mult_pipe.sv
`default_nettype none
// ============================================================================
// mult_pipe : STAGES-deep unsigned WIDTHxWIDTH multiplier, one multiplier slice
//             per stage, with stall, flush and low/high half selection.
// Revision: 1.0
// ============================================================================
module mult_pipe #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 4,
   parameter int TAG_W  = 12
) (
   input  logic       clock,
   input  logic       reset,
   mult_pipe_if.slave bus
);
   localparam int SLICE = WIDTH / STAGES;
   localparam int ACC_W = 2 * WIDTH;
   localparam int LAST  = STAGES - 1;
   localparam int CARRY = (STAGES > 1) ? STAGES - 1 : 1;

   // Per-stage state; operands only travel as far as the last stage that needs them.
   logic             stage_valid  [STAGES];
   logic [ACC_W-1:0] stage_acc    [STAGES];
   logic             stage_high   [STAGES];
   logic [TAG_W-1:0] stage_tag    [STAGES];
   logic [WIDTH-1:0] stage_mplier [CARRY];
   logic [WIDTH-1:0] stage_mcand  [CARRY];

   logic stall;
   logic any_valid;

   assign stall        = stage_valid[LAST] & ~bus.out_ready;
   assign bus.in_ready = ~stall;

   genvar i;
   generate
      for (i = 0; i < STAGES; i++) begin : g_stage
         logic             valid_in;
         logic [ACC_W-1:0] acc_in;
         logic             high_in;
         logic [TAG_W-1:0] tag_in;
         logic [SLICE-1:0] slice;
         logic [WIDTH-1:0] mcand_in;
         logic [ACC_W-1:0] partial;

         if (i == 0) begin : g_head
            assign valid_in = bus.in_valid;
            assign acc_in   = '0;
            assign high_in  = bus.in_high;
            assign tag_in   = bus.in_tag;
            assign slice    = bus.in_mplier[SLICE-1:0];
            assign mcand_in = bus.in_mcand;

            if (LAST > 0) begin : g_carry
               always_ff @(posedge clock) begin
                  if (!stall) begin
                     stage_mplier[0] <= bus.in_mplier;
                     stage_mcand[0]  <= bus.in_mcand;
                  end
               end
            end
         end else begin : g_body
            assign valid_in = stage_valid[i-1];
            assign acc_in   = stage_acc[i-1];
            assign high_in  = stage_high[i-1];
            assign tag_in   = stage_tag[i-1];
            assign slice    = stage_mplier[i-1][i*SLICE +: SLICE];
            assign mcand_in = stage_mcand[i-1];

            if (i < LAST) begin : g_carry
               always_ff @(posedge clock) begin
                  if (!stall) begin
                     stage_mplier[i] <= stage_mplier[i-1];
                     stage_mcand[i]  <= stage_mcand[i-1];
                  end
               end
            end
         end

         assign partial = ACC_W'(slice) * ACC_W'(mcand_in);

         // Reset outranks flush, flush outranks stall; a flush also drops the
         // operation being offered in the same cycle.
         always_ff @(posedge clock) begin
            if (reset || bus.flush) begin
               stage_valid[i] <= 1'b0;
            end else if (!stall) begin
               stage_valid[i] <= valid_in;
            end
         end

         always_ff @(posedge clock) begin
            if (!stall) begin
               stage_acc[i]  <= acc_in + (partial << (i * SLICE));
               stage_high[i] <= high_in;
               stage_tag[i]  <= tag_in;
            end
         end
      end
   endgenerate

   always_comb begin
      any_valid = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         any_valid = any_valid | stage_valid[k];
      end
   end

   assign bus.busy        = any_valid;
   assign bus.out_valid   = stage_valid[LAST];
   assign bus.out_tag     = stage_tag[LAST];
   assign bus.out_product = stage_high[LAST] ? stage_acc[LAST][ACC_W-1:WIDTH]
                                             : stage_acc[LAST][WIDTH-1:0];
endmodule
`default_nettype wire
